alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, registered successor to the combinational 32-bit ALU. It accepts one operation per valid/ready handshake and returns a registered result with overflow, zero and negative flags behind a second valid/ready handshake. It adds an optional iterative unsigned multiplier and sits between the operand-fetch and writeback stages of the lab datapath.

## Interface
- `WIDTH`, default 32: operand and result width, 4 to 64.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  operands and control are valid.
- `in_ready`  out  1  block can accept an operation this cycle.
- `A`, `B`  in  WIDTH  operands.
- `control`  in  3  operation code; encodings are in the package.
- `out_valid`  out  1  result and flags are valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out`  out  WIDTH  result.
- `overflow`, `zero`, `negative`  out  1 each  registered flags.

## Operation
- Operation codes:
  - 0: MUL.
  - 1: reserved.
  - 2: ADD.
  - 3: SUB (A−B).
  - 4: AND.
  - 5: OR.
  - 6: NOR.
  - 7: XOR.
- Accept happens when `in_valid && in_ready` on a rising edge.
- `in_ready` is `(state==IDLE) && (!out_valid || out_ready)`. It is combinational from state and `out_ready`.
- States:
  - IDLE: single-cycle ops load the output register directly. MUL loads the multiplier and goes to MUL_BUSY.
  - MUL_BUSY: one partial-product step per cycle for WIDTH cycles. It then loads the output register and returns to IDLE.
- Output register:
  - Holds `out` and the flags stable while `out_valid && !out_ready`.
  - Clears `out_valid` on handshake unless a new result loads in the same cycle.
- Arithmetic and flags:
  - ADD/SUB results are modulo 2^WIDTH.
  - ADD/SUB `overflow` is two's-complement signed overflow: operand signs agree (ADD) or differ (SUB), and the result sign differs from A.
  - Logic ops force `overflow`=0.
  - MUL is unsigned: `out` is the low WIDTH bits of A*B; `overflow`=1 if the high WIDTH bits are nonzero.
  - Reserved code: `out`=0, `overflow`=0.
  - For every op, `zero` = (`out`==0) and `negative` = `out[WIDTH-1]`.
- Reset values: `out`=0, all flags 0, `out_valid`=0, state IDLE, so `in_ready`=1 in the first cycle after reset.
- Reset during MUL_BUSY abandons the operation and produces no result.
- An operation offered while `in_ready`=0 is not accepted. The source must hold it.

## Timing
- Single-cycle ops: result valid the cycle after accept (latency 1). Throughput is 1 per cycle while `out_ready`=1.
- MUL: accept at cycle t; `out_valid` rises at t+WIDTH+1. `in_ready`=0 from t+1 until the result has loaded and IDLE is re-entered.
- Back-to-back: a new op may be accepted in the same cycle the current result is consumed.

## Configuration
- `ALU_PIPE_MUL_EN` defined: MUL path, MUL_BUSY state and the sub-module are compiled in.
- `ALU_PIPE_MUL_EN` undefined:
  - Code 0 behaves as reserved (`out`=0, `zero`=1, latency 1).
  - The state machine reduces to IDLE only.

## Structure
- Package `alu_pipe_pkg` holds:
  - the `ALU_*` control constants, including `ALU_MUL` and `ALU_RSVD`;
  - the state typedef (IDLE, MUL_BUSY).
- Sub-module `alu_mul_iter` is a shift-add multiplier with start, busy and done outputs and a 2·WIDTH product.
- Combinational add/sub/logic and flag generation stay in `alu_pipe`.

## Test plan
All cases use WIDTH=32.
- ADD 8+4, `out_ready`=1 → next cycle `out`=12, flags 0,0,0.
- ADD 0x7FFFFFFF+0x7FFFFFFF → `out`=0xFFFFFFFE, `overflow`=1, `negative`=1. ADD 0xFFFFFFFF+1 → `out`=0, `zero`=1, `overflow`=0.
- SUB 2−5 → `out`=0xFFFFFFFD, `negative`=1. SUB 0x80000000−0x0FFFFFFF → `out`=0x70000001, `overflow`=1.
- AND 0xFFFFFFFF & 1 → 1. OR 0xFFFF0000 | 0x0000FFFF → 0xFFFFFFFF, `negative`=1. NOR 0x0000FFFF, 0xFFFF0000 → 0, `zero`=1. XOR 0xF0F0F0F0 ^ 0xFF00FF00 → 0x0FF00FF0.
- With `ALU_PIPE_MUL_EN`:
  - MUL 0x10000×0x10000 → after 33 cycles `out`=0, `overflow`=1, `zero`=1.
  - MUL 7×6 → `out`=42.
  - `in_ready`=0 throughout MUL_BUSY.
  - Reset at cycle 10 of a MUL → no `out_valid`, `in_ready`=1 the next cycle.
- Backpressure: hold `out_ready`=0 for 5 cycles after ADD 1+1 → `out`=2 stable, `in_ready`=0. Raise `out_ready` with a new op valid → that op is accepted in the same cycle.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// +------------------------------------------------------------------+
// | alu_pipe_pkg : operation codes and FSM states for alu_pipe       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package alu_pipe_pkg;

  localparam logic [2:0] ALU_MUL  = 3'd0;
  localparam logic [2:0] ALU_RSVD = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_XOR  = 3'd7;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// +------------------------------------------------------------------+
// | alu_mul_iter : unsigned shift-add multiplier, one bit per cycle  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int               CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    STEPS = CW'(WIDTH);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     w_sum;

  // Upper half accumulates the multiplicand; the whole register shifts right
  // each step so the multiplier bits drain out of the low half.
  assign w_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                 (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start) begin
      mcand_d = a;
      prod_d  = {{WIDTH{1'b0}}, b};
      count_d = STEPS;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      prod_d  = {w_sum, prod_q[WIDTH-1:1]};
      count_d = count_q - CW'(1);
      if (count_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q <= '0;
      prod_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// +------------------------------------------------------------------+
// | alu_pipe : registered ALU with valid/ready handshakes; the       |
// | iterative multiplier is built only when ALU_PIPE_MUL_EN is set.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  logic [WIDTH-1:0] w_sum, w_diff, w_alu_res, w_load_res;
  logic             w_alu_ovf, w_load_ovf, w_load, w_accept;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;

  assign w_sum    = A + B;
  assign w_diff   = A - B;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (control)
      ALU_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_AND: w_alu_res = A & B;
      ALU_OR:  w_alu_res = A | B;
      ALU_NOR: w_alu_res = ~(A | B);
      ALU_XOR: w_alu_res = A ^ B;
      default: w_alu_res = '0;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  state_t               state_q, state_d;
  logic                 w_mul_start, w_mul_busy, w_mul_done;
  logic [2*WIDTH-1:0]   w_mul_product;

  assign in_ready    = (state_q == IDLE) && !w_mul_busy && (!out_valid_q || out_ready);
  assign w_mul_start = w_accept && (control == ALU_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (w_mul_start),
    .a       (A),
    .b       (B),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  always_comb begin
    state_d    = state_q;
    w_load     = 1'b0;
    w_load_res = w_alu_res;
    w_load_ovf = w_alu_ovf;
    case (state_q)
      IDLE: begin
        if (w_mul_start) begin
          state_d = MUL_BUSY;
        end else if (w_accept) begin
          w_load = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (w_mul_done) begin
          state_d    = IDLE;
          w_load     = 1'b1;
          w_load_res = w_mul_product[WIDTH-1:0];
          w_load_ovf = |w_mul_product[2*WIDTH-1:WIDTH];
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    w_load     = w_accept;
    w_load_res = w_alu_res;
    w_load_ovf = w_alu_ovf;
  end
`endif

  // A load in the same cycle as a handshake overrides the clear.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (w_load) begin
      out_valid_d = 1'b1;
      out_d       = w_load_res;
      overflow_d  = w_load_ovf;
      zero_d      = (w_load_res == '0);
      negative_d  = w_load_res[WIDTH-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// +------------------------------------------------------------------+
// | tb_alu_pipe : table and scoreboard bench for alu_pipe, WIDTH=32  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         zro;
    logic         neg;
  } exp_t;

  typedef struct {
    logic [2:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [2:0]   control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dut_out;
  logic         overflow, zero, negative;

  exp_t sb[$];
  exp_t drv_exp;
  exp_t mon_e;
  vec_t tv[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  alu_pipe #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dut_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mke(logic [W-1:0] r, logic o, logic z, logic n);
    exp_t e;
    e.res = r; e.ovf = o; e.zro = z; e.neg = n;
    return e;
  endfunction

  function automatic vec_t mk(logic [2:0] c, logic [W-1:0] x, logic [W-1:0] y,
                              logic [W-1:0] r, logic o, logic z, logic n);
    vec_t v;
    v.c = c; v.a = x; v.b = y; v.e = mke(r, o, z, n);
    return v;
  endfunction

  // Scoreboard: pop on output handshake, push on input handshake.
  always @(negedge clock) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h expected no output", dut_out);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_out",      {32'd0, dut_out}, {32'd0, mon_e.res});
        chk("sb_overflow", {63'd0, overflow}, {63'd0, mon_e.ovf});
        chk("sb_zero",     {63'd0, zero},     {63'd0, mon_e.zro});
        chk("sb_negative", {63'd0, negative}, {63'd0, mon_e.neg});
      end
    end
    if (reset === 1'b0 && in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(drv_exp);
  end

  task automatic send(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                      input exp_t e, output int waits);
    logic acc;
    logic fin;
    control  = c;
    a        = x;
    b        = y;
    drv_exp  = e;
    in_valid = 1'b1;
    waits    = 0;
    fin      = 1'b0;
    while (!fin) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      if (acc === 1'b1) begin
        fin = 1'b1;
      end else begin
        waits++;
        if (waits >= 200) begin
          chk("accept_timeout", 64'(waits), 64'd0);
          fin = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int   w;
    int   lat;
    logic seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    control   = ALU_ADD;
    drv_exp   = mke('0, 1'b0, 1'b0, 1'b0);

    tv.push_back(mk(ALU_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1));
    tv.push_back(mk(ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0));
    tv.push_back(mk(ALU_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0));
    tv.push_back(mk(ALU_SUB, 32'h00000002, 32'h00000005, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b1));
    tv.push_back(mk(ALU_SUB, 32'h80000000, 32'h0FFFFFFF, 32'h70000001, 1'b1, 1'b0, 1'b0));
    tv.push_back(mk(ALU_SUB, 32'h00000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1));
    tv.push_back(mk(ALU_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b0));
    tv.push_back(mk(ALU_AND, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0));
    tv.push_back(mk(ALU_OR,  32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1));
    tv.push_back(mk(ALU_NOR, 32'h0000FFFF, 32'hFFFF0000, 32'h00000000, 1'b0, 1'b1, 1'b0));
    tv.push_back(mk(ALU_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1));
    tv.push_back(mk(ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0));
    tv.push_back(mk(ALU_RSVD, 32'h00000005, 32'h00000006, 32'h00000000, 1'b0, 1'b1, 1'b0));
`ifndef ALU_PIPE_MUL_EN
    tv.push_back(mk(ALU_MUL, 32'h00000007, 32'h00000006, 32'h00000000, 1'b0, 1'b1, 1'b0));
`endif

    cycles(2);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out",       {32'd0, dut_out},   64'd0);
    chk("rst_flags",     {61'd0, overflow, zero, negative}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    cycles(1);

    // Latency-1 check on ADD 8+4
    send(ALU_ADD, 32'd8, 32'd4, mke(32'd12, 1'b0, 1'b0, 1'b0), w);
    @(negedge clock);
    chk("lat1_valid", {63'd0, out_valid}, 64'd1);
    chk("lat1_out",   {32'd0, dut_out},   64'd12);
    cycles(1);

    // Back-to-back table, one op per cycle
    foreach (tv[i]) begin
      send(tv[i].c, tv[i].a, tv[i].b, tv[i].e, w);
      chk("table_accept_wait", 64'(w), 64'd0);
    end
    cycles(3);

    // Backpressure holds the result and blocks input
    out_ready = 1'b0;
    send(ALU_ADD, 32'd1, 32'd1, mke(32'd2, 1'b0, 1'b0, 1'b0), w);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_valid",    {63'd0, out_valid}, 64'd1);
      chk("bp_out",      {32'd0, dut_out},   64'd2);
      chk("bp_in_ready", {63'd0, in_ready},  64'd0);
      cycles(1);
    end
    control   = ALU_ADD;
    a         = 32'd3;
    b         = 32'd4;
    drv_exp   = mke(32'd7, 1'b0, 1'b0, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("bb_in_ready", {63'd0, in_ready}, 64'd1);
    cycles(1);
    in_valid = 1'b0;
    @(negedge clock);
    chk("bb_valid", {63'd0, out_valid}, 64'd1);
    chk("bb_out",   {32'd0, dut_out},   64'd7);
    cycles(2);

    // Reset discards a pending result
    out_ready = 1'b0;
    send(ALU_ADD, 32'd5, 32'd5, mke(32'd10, 1'b0, 1'b0, 1'b0), w);
    @(negedge clock);
    chk("pend_valid", {63'd0, out_valid}, 64'd1);
    cycles(1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    sb.delete();
    @(negedge clock);
    chk("pend_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("pend_rst_out",   {32'd0, dut_out},   64'd0);
    out_ready = 1'b1;
    cycles(1);

`ifdef ALU_PIPE_MUL_EN
    send(ALU_MUL, 32'h10000, 32'h10000, mke(32'd0, 1'b1, 1'b1, 1'b0), w);
    lat  = -1;
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clock);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        lat  = k - 1;
      end else begin
        chk("mul_busy_in_ready", {63'd0, in_ready}, 64'd0);
        cycles(1);
      end
    end
    chk("mul_latency", 64'(lat), 64'(W + 1));
    cycles(1);

    send(ALU_MUL, 32'd7, 32'd6, mke(32'd42, 1'b0, 1'b0, 1'b0), w);
    cycles(W + 4);

    send(ALU_MUL, 32'd3, 32'd5, mke(32'd15, 1'b0, 1'b0, 1'b0), w);
    cycles(9);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    sb.delete();
    @(negedge clock);
    chk("mrst_in_ready", {63'd0, in_ready},  64'd1);
    chk("mrst_valid",    {63'd0, out_valid}, 64'd0);
    seen = 1'b0;
    repeat (W + 8) begin
      @(negedge clock);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("mrst_no_result", {63'd0, seen}, 64'd0);
    cycles(1);
`endif

    cycles(3);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
